// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM state encoding and default width.
package arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_add.sv
// Combinational 1-bit full-adder cell; the mirror of full_sub.
module full_add (
  input  logic a,
  input  logic b,
  input  logic carryIn,
  output logic sum,
  output logic carryOut
);

  assign sum      = a ^ b ^ carryIn;
  assign carryOut = (a & b) | (a & carryIn) | (b & carryIn);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-add cell plus a carry flip-flop,
// processing one bit per clock with a start/done handshake.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  // Only WIDTH-1 bits are stored: the final bit goes straight into sum.
  logic [WIDTH-2:0] acc_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] acc_d;

  full_add u_full_add (
    .a        (op_a_q[0]),
    .b        (op_b_q[0]),
    .carryIn  (carry_q),
    .sum      (fa_s),
    .carryOut (fa_c)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  assign acc_d = {fa_s, acc_q};

  // Control FSM and the whole datapath; outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= carryIn;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
          op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
          carry_q <= fa_c;
          acc_q   <= acc_d[WIDTH-1:1];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            sum_q   <= acc_d;
            cout_q  <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign carryOut = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed/random bench for serial_adder (WIDTH=8) with a result scoreboard.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       carryIn;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carryOut;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] last_res;

  serial_adder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryIn  (carryIn),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Bench model of full_sub: ripple-borrow difference, bit by bit.
  function automatic logic [7:0] model_sub(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    logic       br;
    br = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~x[i] & br) | (y[i] & br);
    end
    return d;
  endfunction

  // One complete operation from an idle DUT; checks timing and result.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic ci);
    int         busy_cnt;
    int         done_cnt;
    int         done_at;
    logic       overlap;
    logic [8:0] e;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    overlap  = 1'b0;
    @(negedge clk);
    a = oa; b = ob; carryIn = ci; start = 1'b1;
    @(posedge clk);
    exp_q.push_back({1'b0, oa} + {1'b0, ob} + {8'd0, ci});
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = j;
          e = exp_q.pop_front();
          check("result", {23'd0, carryOut, sum}, {23'd0, e});
          last_res = e;
          $display("op a=%h b=%h cin=%b -> sum=%h cout=%b (exp %h)", oa, ob, ci, sum, carryOut, e);
        end
      end
    end
    if (done_at < 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("op a=%h b=%h cin=%b -> no completion", oa, ob, ci);
    end
    check("done_latency", done_at, 8);
    check("done_pulses", done_cnt, 1);
    check("busy_cycles", busy_cnt, 8);
    check("busy_done_overlap", {31'd0, overlap}, 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic [8:0] e;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; carryIn = 1'b0;
    last_res = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {21'd0, busy, done, carryOut, sum}, 32'd0);
    rst = 1'b0;

    // Idle with start low for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {21'd0, busy, done, carryOut, sum}, 32'd0);
    end

    // Basic zero and carry boundaries
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    run_op(8'h00, 8'h00, 1'b1);

    // Round trip through the full_sub model
    rd = model_sub(8'h3C, 8'h15);
    check("sub_model", {24'd0, rd}, 32'h27);
    run_op(rd, 8'h15, 1'b0);
    check("roundtrip_fixed", {24'd0, sum}, 32'h3C);
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rd = model_sub(ra, rb);
      run_op(rd, rb, 1'b0);
      check("roundtrip_rand", {24'd0, sum}, {24'd0, ra});
    end

    // start held high with operands changing every cycle
    @(negedge clk);
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    carryIn = 1'($urandom_range(0, 1)); start = 1'b1;
    for (int op = 0; op < 5; op++) begin
      @(posedge clk);
      exp_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, carryIn});
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (j < 8) begin
          check("held_busy", {30'd0, busy, done}, 32'd2);
          check("held_sum_hold", {23'd0, carryOut, sum}, {23'd0, last_res});
        end else if (j == 8) begin
          check("held_done", {30'd0, busy, done}, 32'd1);
          e = exp_q.pop_front();
          check("held_result", {23'd0, carryOut, sum}, {23'd0, e});
          $display("held op %0d -> sum=%h cout=%b (exp %h)", op, sum, carryOut, e);
          last_res = e;
        end else begin
          check("held_done_fall", {30'd0, busy, done}, 32'd0);
        end
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        carryIn = 1'($urandom_range(0, 1));
        if (op == 4 && j == 9) start = 1'b0;
      end
    end

    // Reset during SHIFT aborts the operation
    run_op(8'h80, 8'h80, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; carryIn = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("abort_outputs", {21'd0, busy, done, carryOut, sum}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_quiet", {21'd0, busy, done, carryOut, sum}, 32'd0);
    end
    $display("reset mid-shift -> sum=%h cout=%b", sum, carryOut);
    run_op(8'h12, 8'h34, 1'b0);
    check("post_reset_sum", {23'd0, carryOut, sum}, 32'h046);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
